// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the instruction-fetch and data ports.
// Optional macro ARB_TIMEOUT_EN bounds the mem_ready wait and raises a sticky timeout_err.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_DATA_BURST = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_valid,
  output logic                  stall_if,
  output logic                  stall_dm,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  timeout_err
);

  localparam int unsigned BURST_W = $clog2(MAX_DATA_BURST + 1);

  typedef enum logic [1:0] {IDLE, DATA, FETCH, DONE} state_t;

  state_t                state_q;
  logic [BURST_W-1:0]    burst_q;
  logic                  if_valid_q;
  logic                  dm_valid_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] dm_rdata_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic                  burst_sat;
  logic                  grant_dm;
  logic                  grant_if;
  logic                  busy;
  logic                  timeout_hit;
  logic                  access_end;
  logic [DATA_WIDTH-1:0] end_rdata;

  // Data wins a tie until it has taken MAX_DATA_BURST grants in a row past a waiting fetch.
  always_comb begin
    burst_sat  = (burst_q >= BURST_W'(MAX_DATA_BURST));
    grant_dm   = dm_req && (!if_req || !burst_sat);
    grant_if   = !grant_dm && if_req;
    busy       = (state_q == DATA) || (state_q == FETCH);
    access_end = mem_ready || timeout_hit;
    end_rdata  = mem_ready ? mem_rdata : '0;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_q;
  logic              timeout_err_q;

  assign timeout_hit = busy && !mem_ready && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        wait_q <= '0;
      end else if (busy && !mem_ready) begin
        wait_q <= wait_q + 1'b1;
      end
      if (timeout_hit) begin
        timeout_err_q <= 1'b1;
      end
    end
  end
`else
  // TIMEOUT_CYCLES has no role when the wait is unbounded.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      burst_q     <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_dm) begin
            state_q     <= DATA;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_we;
            mem_addr_q  <= dm_addr;
            mem_wdata_q <= dm_wdata;
            burst_q     <= if_req ? burst_q + 1'b1 : '0;
          end else if (grant_if) begin
            state_q    <= FETCH;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= if_addr;
            burst_q    <= '0;
          end
        end
        DATA, FETCH: begin
          if (access_end) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            if (state_q == FETCH) begin
              if_rdata_q <= end_rdata;
              if_valid_q <= 1'b1;
            end else begin
              dm_valid_q <= 1'b1;
              if (!mem_we_q) begin
                dm_rdata_q <= end_rdata;
              end
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          if_valid_q <= 1'b0;
          dm_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_valid  = dm_valid_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_dm  = dm_req & ~dm_valid_q;

endmodule
